// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// A fetch-queue entry pairs a returned instruction word with the PC it was fetched from.
package fetch_pkg;

  localparam int FETCH_XLEN  = 32;
  localparam int INSTR_BYTES = 4;
  // Reserved for bubble insertion in ID; the fetch stage itself drives zero while empty.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] instr;
  } fetch_entry_t;

  // Pointer width for a circular buffer of n slots (at least one bit).
  function automatic int ptr_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch entries with flush; the head is read straight from storage.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         push_i,
  input  fetch_entry_t entry_i,
  input  logic         pop_i,
  output fetch_entry_t head_o,
  output logic [CW-1:0] count_o
);

  localparam int AW = ptr_width(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  // NOTE: every signal assigned here gets a default first, so no latch is inferred.
  always_comb begin
    do_pop   = pop_i && (count_q != '0);
    do_push  = push_i && ((count_q != CW'(DEPTH)) || do_pop);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; count_q alone says which slots hold data.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= entry_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, pipelines imem requests, queues returned words for ID.
// Optional performance counters are built when IF_FETCH_PERF_EN is defined. XLEN must equal FETCH_XLEN.
module if_fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN            = FETCH_XLEN,
  parameter logic [XLEN-1:0] RESET_PC        = '0,
  parameter int              FQ_DEPTH        = 4,
  parameter int              MAX_OUTSTANDING = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rsp_valid_i,
  input  logic [XLEN-1:0] imem_rsp_data_i,
  input  logic            branch_en_i,
  input  logic [XLEN-1:0] branch_target_i,
  output logic            instr_valid_o,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] instr_pc_o,
  input  logic            instr_ready_i
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [XLEN-1:0] perf_fetched_o,
  output logic [XLEN-1:0] perf_discarded_o,
  output logic [XLEN-1:0] perf_starve_o
`endif
);

  localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int TW  = ptr_width(MAX_OUTSTANDING);
  localparam int QCW = $clog2(FQ_DEPTH + 1);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [OW-1:0]   outst_q, outst_d;
  logic [OW-1:0]   discard_q, discard_d;
  logic [XLEN-1:0] tag_mem_q [MAX_OUTSTANDING];
  logic [TW-1:0]   tag_rd_q, tag_rd_d;
  logic [TW-1:0]   tag_wr_q, tag_wr_d;

  logic            req_hs;
  logic            rsp_keep;
  logic            q_pop;
  logic [QCW-1:0]  q_count;
  fetch_entry_t    q_entry;
  fetch_entry_t    q_head;

  function automatic logic [TW-1:0] tag_next(input logic [TW-1:0] ptr);
    return (ptr == TW'(MAX_OUTSTANDING - 1)) ? '0 : ptr + TW'(1);
  endfunction

  // A request is only issued when its response is guaranteed a queue slot.
  assign imem_req_o = !rst_i && !branch_en_i
                   && (outst_q < OW'(MAX_OUTSTANDING))
                   && ((32'(q_count) + 32'(outst_q)) < 32'(FQ_DEPTH));
  assign imem_addr_o = pc_q;
  assign req_hs      = imem_req_o && imem_gnt_i;
  assign rsp_keep    = imem_rsp_valid_i && !branch_en_i && (discard_q == '0);

  always_comb begin
    pc_d      = pc_q;
    outst_d   = outst_q + OW'(req_hs) - OW'(imem_rsp_valid_i);
    discard_d = discard_q;
    tag_rd_d  = tag_rd_q;
    tag_wr_d  = tag_wr_q;
    if (branch_en_i) begin
      // Everything still in flight belongs to the old path, whatever was pending before.
      pc_d      = branch_target_i & ~XLEN'(3);
      outst_d   = outst_q - OW'(imem_rsp_valid_i);
      discard_d = outst_q - OW'(imem_rsp_valid_i);
      tag_rd_d  = '0;
      tag_wr_d  = '0;
    end else begin
      if (req_hs) begin
        pc_d     = pc_q + XLEN'(INSTR_BYTES);
        tag_wr_d = tag_next(tag_wr_q);
      end
      if (imem_rsp_valid_i && (discard_q != '0)) discard_d = discard_q - OW'(1);
      if (rsp_keep) tag_rd_d = tag_next(tag_rd_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q      <= RESET_PC;
      outst_q   <= '0;
      discard_q <= '0;
      tag_rd_q  <= '0;
      tag_wr_q  <= '0;
    end else begin
      pc_q      <= pc_d;
      outst_q   <= outst_d;
      discard_q <= discard_d;
      tag_rd_q  <= tag_rd_d;
      tag_wr_q  <= tag_wr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (req_hs) tag_mem_q[tag_wr_q] <= pc_q;
  end

  assign q_entry = '{pc: tag_mem_q[tag_rd_q], instr: imem_rsp_data_i};
  assign q_pop   = instr_valid_o && instr_ready_i && !branch_en_i;

  fetch_queue #(
    .DEPTH (FQ_DEPTH)
  ) u_fetch_queue (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (branch_en_i),
    .push_i  (rsp_keep),
    .entry_i (q_entry),
    .pop_i   (q_pop),
    .head_o  (q_head),
    .count_o (q_count)
  );

  assign instr_valid_o = (q_count != '0);
  assign instr_o       = instr_valid_o ? q_head.instr : '0;
  assign instr_pc_o    = instr_valid_o ? q_head.pc    : '0;

`ifdef IF_FETCH_PERF_EN
  logic [XLEN-1:0] perf_fetched_q, perf_discarded_q, perf_starve_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_fetched_q   <= '0;
      perf_discarded_q <= '0;
      perf_starve_q    <= '0;
    end else begin
      if (rsp_keep)                          perf_fetched_q   <= perf_fetched_q + XLEN'(1);
      if (imem_rsp_valid_i && !rsp_keep)     perf_discarded_q <= perf_discarded_q + XLEN'(1);
      if (instr_ready_i && !instr_valid_o)   perf_starve_q    <= perf_starve_q + XLEN'(1);
    end
  end

  assign perf_fetched_o   = perf_fetched_q;
  assign perf_discarded_o = perf_discarded_q;
  assign perf_starve_o    = perf_starve_q;
`endif

endmodule
